// File: rtl/mips_instr_encoder.sv
// Program loader: packs instruction descriptions into 32-bit MIPS words and
// streams them to instruction memory at consecutive addresses.
module mips_instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [2:0]        KIND_ILLEGAL = 3'd7;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              fin_pend_q, fin_pend_d;
    logic              legal_xfer;

    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        w = 32'd0;
        case (kind)
            3'd0:    w = {6'd0, rs, rt, rd, shamt, funct};
            3'd1:    w = {6'd35, rs, rt, imm};
            3'd2:    w = {6'd43, rs, rt, imm};
            3'd3:    w = {6'd4, rs, rt, imm};
            3'd4:    w = {6'd5, rs, rt, imm};
            3'd5:    w = {6'd2, target};
            3'd6:    w = {6'd3, target};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    assign legal_xfer = in_valid && (in_kind != KIND_ILLEGAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= BASE_C;
            wdata_q    <= 32'd0;
            count_q    <= '0;
            err_q      <= 1'b0;
            fin_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            err_q      <= err_d;
            fin_pend_q <= fin_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        err_d      = err_q;
        fin_pend_d = fin_pend_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_ACCEPT;
                    addr_d     = BASE_C;
                    count_d    = '0;
                    err_d      = 1'b0;
                    fin_pend_d = 1'b0;
                end
            end
            S_ACCEPT: begin
                if (in_valid && (in_kind == KIND_ILLEGAL)) begin
                    err_d = 1'b1;
                end
                // A legal transfer beats finish; finish is parked until the ack.
                if (legal_xfer) begin
                    wdata_d    = encode(in_kind, in_rs, in_rt, in_rd, in_shamt,
                                        in_funct, in_imm, in_target);
                    fin_pend_d = finish;
                    state_d    = S_WRITE;
                end else if (finish) begin
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (finish) begin
                    fin_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    count_d    = count_q + 1'b1;
                    addr_d     = addr_q + 1'b1;
                    fin_pend_d = 1'b0;
                    if ((count_q + 1'b1 == DEPTH_C) || fin_pend_q || finish) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_ACCEPT);
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign busy      = (state_q == S_ACCEPT) || (state_q == S_WRITE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomised bench for the MIPS program loader with an arithmetic encoding
// model and an address/count scoreboard.
module tb_mips_instr_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              finish = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_kind = 3'd0;
    logic [4:0]        in_rs = 5'd0;
    logic [4:0]        in_rt = 5'd0;
    logic [4:0]        in_rd = 5'd0;
    logic [4:0]        in_shamt = 5'd0;
    logic [5:0]        in_funct = 6'd0;
    logic [15:0]       in_imm = 16'd0;
    logic [25:0]       in_target = 26'd0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack = 1'b0;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;
    int exp_addr = 0;
    int exp_count = 0;
    bit exp_err = 1'b0;

    mips_instr_encoder #(
        .ADDR_W(ADDR_W), .BASE_ADDR(0), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .count(count), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference encoding built from field weights rather than bit concatenation.
    function automatic logic [31:0] ref_word(input int kind, input int rs, input int rt,
                                             input int rd, input int sh, input int fn,
                                             input int imm, input int tgt);
        longint op;
        longint w;
        case (kind)
            1: op = 35;
            2: op = 43;
            3: op = 4;
            4: op = 5;
            5: op = 2;
            6: op = 3;
            default: op = 0;
        endcase
        if (kind == 0)
            w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
              + longint'(sh) * 64 + longint'(fn);
        else if (kind >= 5)
            w = op * 67108864 + longint'(tgt);
        else
            w = op * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
        return w[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic open_session();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_addr  = 0;
        exp_count = 0;
        exp_err   = 1'b0;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_ready", 32'(in_ready), 32'd1);
        check_eq("start_count", 32'(count), 32'd0);
        check_eq("start_addr", 32'(mem_addr), 32'd0);
        check_eq("start_err", 32'(err), 32'd0);
    endtask

    task automatic send(input int kind, input int rs, input int rt, input int rd,
                        input int sh, input int fn, input int imm, input int tgt,
                        input bit fin, input int dly);
        int waited;
        logic [31:0] exp_w;
        bit ends;
        waited = 0;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            check_eq("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        check_eq("pre_we", 32'(mem_we), 32'd0);
        in_valid  = 1'b1;
        in_kind   = 3'(kind);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_shamt  = 5'(sh);
        in_funct  = 6'(fn);
        in_imm    = 16'(imm);
        in_target = 26'(tgt);
        finish    = fin;
        step();
        in_valid = 1'b0;
        finish   = 1'b0;
        if (kind == 7) begin
            exp_err = 1'b1;
            check_eq("ill_err", 32'(err), 32'd1);
            check_eq("ill_we", 32'(mem_we), 32'd0);
            check_eq("ill_addr", 32'(mem_addr), 32'(exp_addr));
            return;
        end
        exp_w = ref_word(kind, rs, rt, rd, sh, fn, imm, tgt);
        check_eq("we_rise", 32'(mem_we), 32'd1);
        check_eq("wr_addr", 32'(mem_addr), 32'(exp_addr));
        check_eq("wr_data", mem_wdata, exp_w);
        check_eq("wr_ready", 32'(in_ready), 32'd0);
        for (int d = 0; d < dly; d++) begin
            step();
            check_eq("hold_we", 32'(mem_we), 32'd1);
            check_eq("hold_addr", 32'(mem_addr), 32'(exp_addr));
            check_eq("hold_data", mem_wdata, exp_w);
            check_eq("hold_ready", 32'(in_ready), 32'd0);
            check_eq("hold_count", 32'(count), 32'(exp_count));
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        exp_count++;
        exp_addr++;
        ends = fin || (exp_count == DEPTH);
        $display("word kind=%0d addr=%0d data=0x%08h dly=%0d fin=%0d", kind, exp_addr - 1,
                 exp_w, dly, fin);
        check_eq("ack_we", 32'(mem_we), 32'd0);
        check_eq("ack_count", 32'(count), 32'(exp_count));
        check_eq("ack_addr", 32'(mem_addr), 32'(exp_addr));
        check_eq("ack_done", 32'(done), 32'(ends));
        check_eq("ack_ready", 32'(in_ready), 32'(!ends));
        check_eq("ack_err", 32'(err), 32'(exp_err));
    endtask

    task automatic close_session();
        finish = 1'b1;
        step();
        finish = 1'b0;
        check_eq("fin_done", 32'(done), 32'd1);
        check_eq("fin_busy", 32'(busy), 32'd0);
        check_eq("fin_count", 32'(count), 32'(exp_count));
    endtask

    initial begin
        int n;
        bit fin;
        // Reset values
        #2;
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_data", mem_wdata, 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_flags", {29'd0, busy, done, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed: R add, then lw/beq/jal
        open_session();
        send(0, 1, 2, 3, 0, 32'h20, 0, 0, 1'b0, 0);
        check_eq("r_add_const", ref_word(0, 1, 2, 3, 0, 32'h20, 0, 0), 32'h0022_1820);
        close_session();
        open_session();
        send(1, 29, 8, 0, 0, 0, 16'h0004, 0, 1'b0, 0);
        send(3, 8, 0, 0, 0, 0, 16'hFFFE, 0, 1'b0, 1);
        send(6, 0, 0, 0, 0, 0, 0, 26'h0100000, 1'b0, 3);
        start = 1'b1;          // ignored while busy
        step();
        start = 1'b0;
        check_eq("start_ignored", 32'(count), 32'(exp_count));
        close_session();

        // Illegal kind, then sw at the same address; err stays sticky
        open_session();
        send(7, 3, 3, 3, 3, 3, 3, 3, 1'b0, 0);
        send(2, 29, 8, 0, 0, 0, 16'h0004, 0, 1'b0, 2);
        close_session();
        check_eq("err_sticky", 32'(err), 32'd1);
        open_session();

        // Capacity: four words then auto-DONE; fifth offer refused
        for (int i = 0; i < DEPTH; i++)
            send(int'($urandom_range(0, 6)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 26'h3FFFFFF)), 1'b0, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("full_we", 32'(mem_we), 32'd0);
            check_eq("full_ready", 32'(in_ready), 32'd0);
            check_eq("full_count", 32'(count), 32'd4);
        end
        in_valid = 1'b0;
        finish = 1'b1;         // ignored when already DONE
        step();
        finish = 1'b0;
        check_eq("done_hold", 32'(done), 32'd1);

        // finish coincident with the second transfer
        open_session();
        send(0, 4, 5, 6, 7, 8, 0, 0, 1'b0, 0);
        send(4, 9, 10, 0, 0, 0, 16'h8001, 0, 1'b1, 1);
        check_eq("fin2_count", 32'(count), 32'd2);

        // Randomised sessions
        for (int s = 0; s < 12; s++) begin
            open_session();
            n = int'($urandom_range(1, DEPTH));
            fin = 1'b0;
            for (int i = 0; i < n; i++) begin
                fin = (i == n - 1) && (n < DEPTH) && ($urandom_range(0, 1) == 1);
                send(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 65535)), int'($urandom_range(0, 26'h3FFFFFF)), fin,
                     int'($urandom_range(0, 3)));
            end
            if (!done) close_session();
        end

        // Asynchronous reset while a write is pending
        open_session();
        in_valid = 1'b1;
        in_kind  = 3'd5;
        in_target = 26'h155;
        step();
        in_valid = 1'b0;
        check_eq("pre_rst_we", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_we", 32'(mem_we), 32'd0);
        check_eq("arst_addr", 32'(mem_addr), 32'd0);
        check_eq("arst_data", mem_wdata, 32'd0);
        check_eq("arst_count", 32'(count), 32'd0);
        check_eq("arst_flags", {28'd0, in_ready, busy, done, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Sequential program loader for the single-cycle MIPS core, acting as the encoder counterpart of the main control decoder. It accepts instruction descriptions (class plus fields) over a valid/ready handshake and assembles 32-bit MIPS words using the opcode set the decoder understands: R=0, lw=35, sw=43, beq=4, bne=5, j=2, jal=3. Each word is written to instruction memory at consecutive word addresses through an acknowledged write port. The block sits between the testbench/host and the instruction memory, and is used before the core is released from reset.

Parameters:
ADDR_W, 8, instruction-memory word-address width
BASE_ADDR, 0, first word address written after start
DEPTH, 256, maximum words per session (BASE_ADDR+DEPTH <= 2^ADDR_W)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; opens a load session
finish  input  1  one-cycle pulse; closes the session
in_valid  input  1  instruction description valid
in_ready  output  1  encoder can accept
in_kind  input  3  0=R,1=lw,2=sw,3=beq,4=bne,5=j,6=jal,7=illegal
in_rs / in_rt / in_rd / in_shamt  input  5 each  register and shift fields
in_funct  input  6  R-type function
in_imm  input  16  I-type immediate/offset
in_target  input  26  J-type target
mem_we  output  1  write request, held until mem_ack
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  encoded instruction
mem_ack  input  1  memory accepted write this cycle
count  output  ADDR_W+1  words written this session
busy  output  1  session open (state != IDLE/DONE)
done  output  1  session closed; held until next start
err  output  1  sticky: illegal kind seen; cleared by start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, busy=0, done=0, err=0.
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE/DONE + start: -> ACCEPT; mem_addr=BASE_ADDR, count=0, err=0, done=0.
- ACCEPT: in_ready=1. Transfer = in_valid&in_ready.
  - Legal kind: register encoded word into mem_wdata; -> WRITE. mem_we=1 on the next cycle (1-cycle latency).
  - kind=7: err<=1; nothing written; remain in ACCEPT.
  - finish with no transfer: -> DONE, done=1.
  - finish and transfer in the same cycle: the transfer wins. finish is remembered and applied after that write's ack.
- WRITE: in_ready=0; mem_we, mem_addr and mem_wdata are held stable until mem_ack. On ack:
  - mem_we=0, count+1, mem_addr+1.
  - Next state is DONE if count+1==DEPTH or finish is pending, else ACCEPT.
  - An ack in the same cycle mem_we rises counts. Zero-wait memory gives one word per 2 cycles.
- Encoding:
  - R: {6'd0, rs, rt, rd, shamt, funct}.
  - lw/sw/beq/bne: {op, rs, rt, imm}.
  - j/jal: {op, target}.
  - Unused input fields are ignored.
- Capacity: when DEPTH words are written -> DONE automatically. Further in_valid is not accepted (in_ready=0). mem_addr stops at BASE_ADDR+DEPTH, no wrap.
- start while busy: ignored. finish while IDLE/DONE: ignored.
- mem_ack outside WRITE: ignored.
- Reset mid-WRITE: mem_we drops immediately (async); partial word is lost.
- busy=1 in ACCEPT and WRITE; done=1 only in DONE.

Test Plan:
1. Reset, start, send R add (rs=1, rt=2, rd=3, shamt=0, funct=0x20), ack immediately -> mem_wdata=0x00221820 at addr 0 with mem_we one cycle after transfer; count=1.
2. Send lw rs=29, rt=8, imm=0x0004, then beq rs=8, rt=0, imm=0xFFFE, then jal target=0x0100000 -> words 0x8FA80004, 0x1100FFFE, 0x0C100000 at addrs 0, 1, 2.
3. Delay mem_ack 3 cycles -> mem_we/addr/wdata stable for 4 cycles; in_ready=0 throughout; count increments once.
4. kind=7 accepted -> err=1, no mem_we, addr unchanged. The next sw (0xAFA80004 fields) is written at the same address; err remains 1 until the next start.
5. DEPTH=4: send 5 words -> after the 4th ack done=1, in_ready=0, count=4, fifth word never accepted. finish pulsed simultaneously with the 2nd transfer -> that word is written, then DONE with count=2.
6. Assert rst_n=0 while mem_we=1 -> all outputs return to reset values the same cycle, with no clock edge required.
